// File: rtl/seg_scan_mux_pkg.sv
// Shared widths and the leading-zero blanking helper for the seven-segment scanner.
// Digit 0 is never blanked; digit i>0 blanks when it and every digit above it are zero.
package seg_disp_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 8;
  localparam int IDX_W      = 3;

  // Walks from the top digit down, so the zero run stops at the first non-zero digit.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [MAX_DIGITS*BCD_W-1:0] active,
    input int                          n
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        zero_above = zero_above & (active[i*BCD_W +: BCD_W] == '0);
        mask[i]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_mux_prescaler.sv
// Free-running divider; adv is high for one cycle out of every DIV.
// With DIV=1 the counter sits at zero and adv is permanently high.
module refresh_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic adv
);

  localparam int              PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign adv = (pre_q == LAST);

  always_comb begin
    pre_d = adv ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode display scanner with a shadow frame buffer that is
// committed only at the frame wrap, plus optional leading-zero blanking.
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
  input  logic                          blank_lz,
  output logic [BCD_W-1:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [IDX_W-1:0]              dig_idx,
  output logic                          frame_tick
);

  localparam int FRAME_W = BCD_W * NUM_DIGITS;

  logic                       adv;
  logic                       wrap;
  logic [FRAME_W-1:0]         shadow_q, shadow_d;
  logic [FRAME_W-1:0]         active_q, active_d;
  logic                       pending_q, pending_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       wrap_q;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [IDX_W-1:0]           dig_q;
  logic                       tick_q;
  logic [MAX_DIGITS*BCD_W-1:0] active_ext;
  logic [NUM_DIGITS-1:0]      blank;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv)
  );

  assign wrap = adv && (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    idx_d = idx_q;
    if (adv) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the wrap cycle bypasses the shadow so it lands in this frame.
  always_comb begin
    shadow_d  = load ? digits_in : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        active_d = digits_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    active_ext                 = '0;
    active_ext[FRAME_W-1:0]    = active_q;
  end

  assign blank = NUM_DIGITS'(lz_mask(active_ext, NUM_DIGITS));

  always_comb begin
    bcd_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        bcd_d = active_q[i*BCD_W +: BCD_W];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_d[gi] = (idx_q != IDX_W'(gi)) | (blank_lz & blank[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      wrap_q    <= 1'b0;
      bcd_q     <= '0;
      an_q      <= '1;
      dig_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      // Delayed twice so the tick lines up with digit 0 of the new frame on the pins.
      wrap_q    <= wrap;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
      dig_q     <= idx_q;
      tick_q    <= wrap_q;
    end
  end

  assign bcd_out    = bcd_q;
  assign an_n       = an_q;
  assign dig_idx    = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4; expected values are
// hand-derived from the edge count k since reset release (frames wrap on edges 16, 32, ...).
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic [2:0]  dig_idx;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;

  seg_scan_mux #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .an_n       (an_n),
    .dig_idx    (dig_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  function automatic int exp_dig(input int kk);
    return ((kk - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] lit(input int d);
    logic [3:0] v;
    v = 4'b0001 << d;
    return ~v;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] f, input int d);
    return f[4*d +: 4];
  endfunction

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    blank_lz  = 1'b0;

    #23;
    check_eq("rst_an", an_n, 4'hF);
    check_eq("rst_bcd", bcd_out, 4'h0);
    check_eq("rst_dig", dig_idx, 3'd0);
    check_eq("rst_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    $display("txn reset-release: scanning two empty frames");
    for (int c = 1; c <= 32; c++) begin
      step();
      check_eq("scan_dig", dig_idx, exp_dig(k));
      check_eq("scan_tick", frame_tick, (k > 1) && (k % 16 == 1));
      check_eq("scan_an", an_n, lit(exp_dig(k)));
    end

    $display("txn tear-free load 1234 at dig_idx=1");
    run_to(37);
    check_eq("tf_dig_before", dig_idx, 3'd1);
    load = 1'b1; digits_in = 16'h1234;
    step();
    load = 1'b0;
    check_eq("tf_pending", dut.pending_q, 1'b1);
    while (k < 63) begin
      step();
      if (k <= 48) check_eq("tf_hold", bcd_out, 4'h0);
      else         check_eq("tf_new", bcd_out, nib(16'h1234, exp_dig(k)));
      if (k == 49) check_eq("tf_tick", frame_tick, 1'b1);
    end

    $display("txn load 5678 on wrap cycle");
    load = 1'b1; digits_in = 16'h5678;
    step();
    load = 1'b0;
    check_eq("wr_last_old", bcd_out, 4'h1);
    step();
    check_eq("wr_bcd", bcd_out, 4'h8);
    check_eq("wr_tick", frame_tick, 1'b1);
    check_eq("wr_dig", dig_idx, 3'd0);
    check_eq("wr_pending", dut.pending_q, 1'b0);
    run_to(69);
    check_eq("wr_d1", bcd_out, 4'h7);

    $display("txn blanking with 0070 then 0000");
    load = 1'b1; digits_in = 16'h0070; blank_lz = 1'b1;
    step();
    load = 1'b0;
    run_to(73);
    check_eq("wr_d2", bcd_out, 4'h6);
    run_to(77);
    check_eq("wr_d3", bcd_out, 4'h5);
    check_eq("bl_noblank_an", an_n, 4'b0111);
    run_to(81);
    check_eq("bl70_an0", an_n, 4'b1110);
    check_eq("bl70_tick", frame_tick, 1'b1);
    run_to(85);
    check_eq("bl70_an1", an_n, 4'b1101);
    check_eq("bl70_bcd1", bcd_out, 4'h7);
    run_to(89);
    check_eq("bl70_an2", an_n, 4'b1111);
    check_eq("bl70_bcd2", bcd_out, 4'h0);
    load = 1'b1; digits_in = 16'h0000;
    step();
    load = 1'b0;
    run_to(93);
    check_eq("bl70_an3", an_n, 4'b1111);
    check_eq("bl70_dig3", dig_idx, 3'd3);
    run_to(97);
    check_eq("bl00_an0", an_n, 4'b1110);
    run_to(101);
    check_eq("bl00_an1", an_n, 4'b1111);
    run_to(105);
    check_eq("bl00_an2", an_n, 4'b1111);
    run_to(109);
    check_eq("bl00_an3", an_n, 4'b1111);
    blank_lz = 1'b0;
    step();
    check_eq("bl_toggle_an", an_n, 4'b0111);

    $display("txn back-to-back loads 1111 then 2222");
    run_to(113);
    load = 1'b1; digits_in = 16'h1111;
    step();
    digits_in = 16'h2222;
    step();
    load = 1'b0;
    run_to(120);
    check_eq("bb_hold_bcd", bcd_out, 4'h0);
    check_eq("bb_hold_an", an_n, 4'b1101);
    run_to(129);
    check_eq("bb_tick", frame_tick, 1'b1);
    for (int d = 0; d < 4; d++) begin
      run_to(129 + 4 * d);
      check_eq("bb_bcd", bcd_out, 4'h2);
      check_eq("bb_an", an_n, lit(d));
    end

    $display("txn async reset mid-frame with 9999 pending");
    run_to(145);
    load = 1'b1; digits_in = 16'h9999;
    step();
    load = 1'b0;
    check_eq("ar_pending_set", dut.pending_q, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("ar_an", an_n, 4'hF);
    check_eq("ar_bcd", bcd_out, 4'h0);
    check_eq("ar_dig", dig_idx, 3'd0);
    check_eq("ar_pending_clr", dut.pending_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      check_eq("ar_bcd_after", bcd_out, 4'h0);
      check_eq("ar_dig_after", dig_idx, exp_dig(k));
      if (k == 17) check_eq("ar_tick", frame_tick, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scanner for a multi-digit common-anode seven-segment display. It holds a frame of BCD digits and steps through them at a fixed refresh rate. Each cycle it presents one digit nibble to the downstream `seven_segdisplay_df` decoder and drives the matching active-low anode. It also supports tear-free frame updates and optional leading-zero blanking.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; legal range 2..8.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 1.

- `clk` input 1: system clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load` input 1: single-cycle strobe; capture `digits_in`.
- `digits_in` input 4*NUM_DIGITS: BCD digits; digit i is at bits [4i+3:4i]; digit 0 is least significant.
- `blank_lz` input 1: enables leading-zero blanking; sampled every cycle.
- `bcd_out` output 4: nibble for the decoder's `bcd` input.
- `an_n` output NUM_DIGITS: anode enables, active-low, one-hot-low or all-high.
- `dig_idx` output 3: index of the currently scanned digit.
- `frame_tick` output 1: one-cycle pulse when the scan wraps from NUM_DIGITS-1 to 0.

## Operation
- **Registers:**
  - `shadow` (4*NUM_DIGITS), `active` (4*NUM_DIGITS), `pending` (1).
  - Prescaler `pre` (clog2(REFRESH_DIV) bits, min 1).
  - `idx` (3 bits).
- **Load:**
  - `load`=1 writes `digits_in` to `shadow` and sets `pending`.
  - Back-to-back loads: the last one wins.
- **Prescaler:**
  - `pre` counts 0..REFRESH_DIV-1 and wraps to 0.
  - `adv` = (`pre` == REFRESH_DIV-1).
  - With REFRESH_DIV=1, `adv` is always 1.
- **Scan:**
  - On `adv`, `idx` increments.
  - At NUM_DIGITS-1 it wraps to 0 and `frame_tick` is asserted that cycle.
- **Frame commit (wrap cycle only):**
  - If `load`=1 in the same cycle, `active` ← `digits_in` and `pending` ← 0. The `shadow` write still occurs.
  - Else if `pending`, `active` ← `shadow` and `pending` ← 0.
  - Otherwise `active` is unchanged.
  - `active` never changes mid-frame, so there is no tearing.
- **Blanking:**
  - Digit i>0 is blanked when `blank_lz`=1 and `active` digits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives `an_n` all-high; `bcd_out` still carries the nibble.
- **Outputs (registered from the current `idx`/`active`):**
  - `bcd_out` = `active[idx]`.
  - `an_n` = ~(1<<`idx`), or all-high if blanked.
  - `dig_idx` = `idx`.
- **Digit values:** non-BCD nibbles (A..F) pass through unmodified; the decoder shows a dash for them.

## Timing
- **Reset values:**
  - `pre`=0, `idx`=0, `shadow`=0, `active`=0, `pending`=0.
  - `bcd_out`=0, `an_n`=all-high, `dig_idx`=0, `frame_tick`=0.
- **First outputs after reset:** first rising edge after `rst_n` deasserts gives `an_n`=~1 and `bcd_out`=0.
- **Output latency:** outputs lag `idx`/`active` by one cycle. `dig_idx` changes on the cycle after `adv`, together with `an_n`.
- **Dwell:** each digit is lit exactly REFRESH_DIV cycles, so a frame is NUM_DIGITS×REFRESH_DIV cycles.
- **`frame_tick`:**
  - Registered, so it is high in the first cycle showing digit 0 of the new frame.
  - That is the same cycle the committed `active` data first appears on `bcd_out`.
- **Load-to-display latency:**
  - Minimum: 1 cycle, when `load` arrives on the wrap cycle.
  - Maximum: NUM_DIGITS×REFRESH_DIV cycles.
- **Reset mid-operation:** asynchronous. All registers take their reset values immediately and any pending load is discarded.
- **`blank_lz` toggling:** effective on the next output register update, even mid-frame.

## Structure
- **Package `seg_disp_pkg`:**
  - `BCD_W`=4.
  - `MAX_DIGITS`=8.
  - `IDX_W`=3.
  - Function `lz_mask(active, n)` returns the per-digit blank vector.
- **Sub-module `refresh_prescaler`:** parameter DIV; ports `clk`, `rst_n`, `adv`.
- **Integration:** the top instantiates `refresh_prescaler`. `bcd_out` is wired externally to `seven_segdisplay_df.bcd`.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- **Reset release:**
  - Stimulus: release reset.
  - Response: `an_n`=4'b1110 and `bcd_out`=0 on the first edge.
  - Response: `dig_idx` sequence is 0,1,2,3,0, each held 4 cycles.
  - Response: `frame_tick` pulses every 16 cycles.
- **Tear-free load:**
  - Stimulus: `load` with `digits_in`=16'h1234 while `dig_idx`=1.
  - Response: the display keeps 0000 until the wrap.
  - Response: next frame shows `bcd_out` 4,3,2,1 for `dig_idx` 0..3, with `frame_tick` coincident with digit 4.
- **Load on wrap cycle:**
  - Stimulus: `load` with 16'h5678 asserted exactly on the wrap cycle.
  - Response: `bcd_out`=8 on the following cycle with `frame_tick`=1.
  - Response: `pending` is 0 afterwards.
- **Leading-zero blanking:**
  - Stimulus: `active`=16'h0070 with `blank_lz`=1.
  - Response: `an_n` is 1110, 1101, 1111, 1111 across the frame.
  - Stimulus: `active`=16'h0000 with `blank_lz`=1.
  - Response: only digit 0 is lit.
- **Back-to-back loads:**
  - Stimulus: loads 16'h1111 then 16'h2222 within one frame.
  - Response: the next frame shows 2222.
- **Async reset mid-frame:**
  - Stimulus: assert `rst_n`=0 mid-frame with a load pending.
  - Response: `an_n` is all-high immediately.
  - Response: after release the display shows 0000; the pending data is lost.
